hex_display_scanner: RTL and testbench

// Output-side counterpart of the keypad scan encoder. It takes the 8-bit ALU result and drives a
// two-digit, time-multiplexed common-cathode 7-segment display. The low nibble goes to digit 0 and
// the high nibble to digit 1. New values are captured into a shadow register and applied only at a

---
 rtl/hex_display_scanner.sv | 156 +++++++++++++++
 tb/tb_hex_display_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scanner.sv
// Two-digit, time-multiplexed common-cathode 7-segment driver.
// The low nibble of the displayed value goes to digit 0 and the high nibble to digit 1.
// Incoming values land in a shadow register and are copied to the active register
// only at a frame boundary, so one frame never mixes two values. Every digit slot is
// preceded by a blanking gap to suppress ghosting. All outputs are registered.
// An FSM sequences IDLE -> BLANK -> SHOW -> BLANK ..., and the digit index toggles
// after each SHOW slot.
module hex_display_scanner #(
  parameter logic [23:0] SHOW_CYCLES  = 24'd10_000,  // must be >= 2
  parameter logic [7:0]  BLANK_CYCLES = 8'd16        // must be >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       flag_in,
  input  logic       lzb,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_sel,
  output logic       frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam int unsigned SHOW_N  = 32'(SHOW_CYCLES);
  localparam int unsigned BLANK_N = 32'(BLANK_CYCLES);
  localparam int unsigned MAX_N   = (SHOW_N > BLANK_N) ? SHOW_N : BLANK_N;
  localparam int          CW      = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_N - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_N - 1);

  // Hex digit to {g,f,e,d,c,b,a}, active high.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          idx_q, idx_d;
  logic [8:0]    shadow_q, shadow_d;   // {flag, data}
  logic [8:0]    active_q, active_d;   // {flag, data}
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    sel_q, sel_d;
  logic          fd_q, fd_d;
  logic          boundary;
  logic [3:0]    nib;

  // Scan sequencing, shadow capture and frame-boundary transfer to the active register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    boundary = 1'b0;
    // A load coinciding with a boundary must be written through, so the
    // boundary copy below takes shadow_d rather than shadow_q.
    shadow_d = load ? {flag_in, data_in} : shadow_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = 1'b0;
          boundary = 1'b1;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d  = ST_BLANK;
            cnt_d    = '0;
            idx_d    = ~idx_q;
            boundary = idx_q;  // leaving digit 1 starts a new frame at digit 0
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = 1'b0;
        end
      endcase
    end
    active_d = boundary ? shadow_d : active_q;
  end

  // Output values for the coming cycle, derived from the next state so they can be registered.
  always_comb begin
    seg_d = 7'h00;
    dp_d  = 1'b0;
    sel_d = 2'b00;
    fd_d  = 1'b0;
    nib   = idx_d ? active_d[7:4] : active_d[3:0];
    if (state_d == ST_SHOW) begin
      fd_d = idx_d && (cnt_d == SHOW_LAST);
      if (!(idx_d && lzb && (active_d[7:4] == 4'h0))) begin
        sel_d = idx_d ? 2'b10 : 2'b01;
        seg_d = decode(nib);
        dp_d  = idx_d ? 1'b0 : active_d[8];
      end
    end
  end

  // State, data and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= '0;
      dp_q     <= 1'b0;
      sel_q    <= 2'b00;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      sel_q    <= sel_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with SHOW_CYCLES=4, BLANK_CYCLES=2.
// The reference model tracks the position within a 12-cycle frame arithmetically
// and latches the displayed value at each frame start.
module tb_hex_display_scanner;

  localparam int S = 4;
  localparam int B = 2;
  localparam int P = 2 * (B + S);

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] data_in;
  logic       load;
  logic       flag_in;
  logic       lzb;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_sel;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  bit         running;
  int         pos;
  logic [8:0] m_shadow;
  logic [8:0] m_active;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [1:0] e_sel;
  logic       e_fd;

  hex_display_scanner #(
    .SHOW_CYCLES (24'd4),
    .BLANK_CYCLES(8'd2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .data_in   (data_in),
    .load      (load),
    .flag_in   (flag_in),
    .lzb       (lzb),
    .seg       (seg),
    .dp        (dp),
    .digit_sel (digit_sel),
    .frame_done(frame_done)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    running  = 1'b0;
    pos      = 0;
    m_shadow = '0;
    m_active = '0;
    e_seg    = '0;
    e_dp     = 1'b0;
    e_sel    = 2'b00;
    e_fd     = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit lit0, lit1, blank1;
    if (!en) begin
      running = 1'b0;
      pos     = 0;
    end else if (!running) begin
      running = 1'b1;
      pos     = 0;
    end else begin
      pos = (pos + 1) % P;
    end
    if (running && pos == 0)
      m_active = load ? {flag_in, data_in} : m_shadow;
    if (load)
      m_shadow = {flag_in, data_in};
    lit0   = running && pos >= B && pos < B + S;
    lit1   = running && pos >= 2 * B + S;
    blank1 = lzb && (m_active[7:4] == 4'h0);
    e_seg  = 7'h00;
    e_dp   = 1'b0;
    e_sel  = 2'b00;
    e_fd   = running && (pos == P - 1);
    if (lit0) begin
      e_seg = seg_tab[m_active[3:0]];
      e_dp  = m_active[8];
      e_sel = 2'b01;
    end else if (lit1 && !blank1) begin
      e_seg = seg_tab[m_active[7:4]];
      e_sel = 2'b10;
    end
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
    check("digit_sel", 16'(digit_sel), 16'(e_sel));
    check("frame_done", 16'(frame_done), 16'(e_fd));
    check("sel_onehot", 16'(digit_sel == 2'b11), 16'd0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Step until the model reaches frame position p (bounded by one frame).
  task automatic step_to(input int p);
    for (int i = 0; i < P + 1; i++) begin
      if (running && pos == p) break;
      step();
    end
    check("step_to_pos", 16'(pos), 16'(p));
  endtask

  task automatic do_load(input logic [7:0] d, input logic f);
    data_in = d;
    flag_in = f;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    data_in = '0;
    load    = 1'b0;
    flag_in = 1'b0;
    lzb     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seg", 16'(seg), 16'h00);
    check("rst_sel", 16'(digit_sel), 16'h0);
    check("rst_fd", 16'(frame_done), 16'h0);
    rst_n = 1'b1;

    // basic scan 0x3A with flag
    do_load(8'h3A, 1'b1);
    en = 1'b1;
    steps(B);
    step();
    check("basic_d0_seg", 16'(seg), 16'h77);
    check("basic_d0_dp", 16'(dp), 16'h1);
    steps(2 * P);

    // no tearing: new value during digit-0 SHOW
    step_to(B + 1);
    do_load(8'h51, 1'b0);
    step_to(2 * B + S);
    check("tear_d1_seg", 16'(seg), 16'h4F);
    steps(P + 2);

    // asynchronous reset mid-SHOW
    step_to(B + 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_seg", 16'(seg), 16'h00);
    check("async_dp", 16'(dp), 16'h0);
    check("async_sel", 16'(digit_sel), 16'h0);
    check("async_fd", 16'(frame_done), 16'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    steps(P + 1);

    // leading-zero blank
    en = 1'b0;
    step();
    do_load(8'h05, 1'b0);
    lzb = 1'b1;
    en  = 1'b1;
    steps(2 * P);
    lzb = 1'b0;
    steps(P);

    // enable drop during digit-1 SHOW
    do_load(8'hC7, 1'b1);
    step_to(2 * B + S + 1);
    en = 1'b0;
    step();
    check("drop_sel", 16'(digit_sel), 16'h0);
    steps(2);
    en = 1'b1;
    steps(P + 2);

    // load coinciding with the frame boundary
    step_to(P - 1);
    do_load(8'hFF, 1'b0);
    step_to(B);
    check("coinc_d0_seg", 16'(seg), 16'h71);
    step_to(2 * B + S);
    check("coinc_d1_seg", 16'(seg), 16'h71);
    steps(P);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 19) != 0);
      load    = ($urandom_range(0, 5) == 0);
      data_in = 8'($urandom_range(0, 255));
      flag_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 3) == 0) data_in[7:4] = 4'h0;
      step();
    end
    load = 1'b0;
    steps(P);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
